// File: rtl/ser_bus_master_pkg.sv
// Shared constants and state encoding for the serial-to-bus bridge.
// Bus command codes mirror the legacy include.h definitions.
package ser_bus_master_pkg;

  localparam logic [3:0] MEM_IDLE = 4'd0;
  localparam logic [3:0] DMEM_LW  = 4'b0101;
  localparam logic [3:0] DMEM_SW  = 4'b1101;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_BUS_REQ,
    ST_BUS_WAIT,
    ST_SEND,
    ST_ERR
  } state_e;

endpackage

// File: rtl/ser_bus_master_tx_seq.sv
// Response byte sequencer: emits up to four bytes MSB-first to the UART
// transmitter, ignoring txd_busy for a short guard window after each load.
module ser_tx_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [31:0] word_i,
  input  logic [2:0]  cnt_i,
  input  logic        txd_busy_i,
  output logic [7:0]  tx_data_o,
  output logic        txd_ld_o,
  output logic        active_o
);

  logic [31:0] buf_q;
  logic [2:0]  cnt_q;
  logic [1:0]  guard_q;
  logic [7:0]  data_q;
  logic        ld_q;
  logic        can_load;

  // Guard covers the load cycle and the two after it, since busy may rise late.
  assign can_load = (cnt_q != 3'd0) && !txd_busy_i && (guard_q == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      guard_q <= '0;
      data_q  <= '0;
      ld_q    <= 1'b0;
    end else begin
      ld_q <= 1'b0;
      if (guard_q != 2'd0) guard_q <= guard_q - 2'd1;
      if (start_i) begin
        buf_q <= word_i;
        cnt_q <= cnt_i;
      end else if (can_load) begin
        data_q  <= buf_q[31:24];
        ld_q    <= 1'b1;
        buf_q   <= {buf_q[23:0], 8'h00};
        cnt_q   <= cnt_q - 3'd1;
        guard_q <= 2'd3;
      end
    end
  end

  assign tx_data_o = data_q;
  assign txd_ld_o  = ld_q;
  assign active_o  = (cnt_q != 3'd0);

endmodule

// File: rtl/ser_bus_master.sv
// Serial-to-bus bridge: framed UART commands become single-word bus
// writes/reads, answered with an ack byte or the four read data bytes.
module ser_bus_master
  import ser_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rxd_rdy,
  output logic        rxd_ft,
  output logic [7:0]  tx_data,
  output logic        txd_ld,
  input  logic        txd_busy,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_dout,
  output logic [3:0]  bus_mem_ctl,
  input  logic        bus_gnt,
  input  logic [31:0] bus_din,
  output logic        frame_err
);

  state_e      state_q;
  logic        is_rd_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] to_cnt_q;
  logic [1:0]  lat_cnt_q;
  logic        ft_q, ft_hold_q;
  logic        err_q;
  logic [31:0] bus_addr_q, bus_dout_q;
  logic [3:0]  ctl_q;
  logic        seq_start_q;
  logic [31:0] seq_word_q;
  logic [2:0]  seq_cnt_q;
  logic        tx_active;
  logic        take;

  // A byte is not sampled while rxd_ft is high nor in the cycle after,
  // because the UART's rdy may still be stale there.
  always_comb begin
    take = rxd_rdy && !ft_q && !ft_hold_q &&
           (state_q == ST_IDLE || state_q == ST_GET_ADDR || state_q == ST_GET_DATA);
    addr_d = addr_q;
    data_d = data_q;
    if (take && state_q == ST_GET_ADDR) addr_d = {addr_q[23:0], rx_data};
    if (take && state_q == ST_GET_DATA) data_d = {data_q[23:0], rx_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      is_rd_q     <= 1'b0;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      to_cnt_q    <= '0;
      lat_cnt_q   <= '0;
      ft_q        <= 1'b0;
      ft_hold_q   <= 1'b0;
      err_q       <= 1'b0;
      bus_addr_q  <= '0;
      bus_dout_q  <= '0;
      ctl_q       <= MEM_IDLE;
      seq_start_q <= 1'b0;
      seq_word_q  <= '0;
      seq_cnt_q   <= '0;
    end else begin
      ft_q        <= 1'b0;
      ft_hold_q   <= ft_q;
      err_q       <= 1'b0;
      seq_start_q <= 1'b0;
      addr_q      <= addr_d;
      data_q      <= data_d;
      unique case (state_q)
        ST_IDLE: begin
          if (take) begin
            ft_q       <= 1'b1;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            if (rx_data == OP_WR || rx_data == OP_RD) begin
              is_rd_q <= (rx_data == OP_RD);
              state_q <= ST_GET_ADDR;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_ERR;
            end
          end
        end
        ST_GET_ADDR, ST_GET_DATA: begin
          if (take) begin
            ft_q       <= 1'b1;
            to_cnt_q   <= '0;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              if (state_q == ST_GET_ADDR && !is_rd_q) begin
                state_q <= ST_GET_DATA;
              end else begin
                state_q    <= ST_BUS_REQ;
                bus_addr_q <= addr_d;
                bus_dout_q <= data_d;
                ctl_q      <= is_rd_q ? DMEM_LW : DMEM_SW;
              end
            end
          end else if (to_cnt_q == 32'(TIMEOUT - 1)) begin
            state_q  <= ST_IDLE;
            err_q    <= 1'b1;
            to_cnt_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end
        end
        ST_BUS_REQ: begin
          if (bus_gnt) begin
            ctl_q <= MEM_IDLE;
            if (is_rd_q) begin
              lat_cnt_q <= 2'd1;
              state_q   <= ST_BUS_WAIT;
            end else begin
              seq_start_q <= 1'b1;
              seq_word_q  <= {RSP_ACK, 24'h0};
              seq_cnt_q   <= 3'd1;
              state_q     <= ST_SEND;
            end
          end
        end
        ST_BUS_WAIT: begin
          if (lat_cnt_q == 2'(RD_LAT)) begin
            seq_start_q <= 1'b1;
            seq_word_q  <= bus_din;
            seq_cnt_q   <= 3'd4;
            state_q     <= ST_SEND;
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end
        ST_SEND: begin
          if (!seq_start_q && !tx_active) state_q <= ST_IDLE;
        end
        ST_ERR: begin
          seq_start_q <= 1'b1;
          seq_word_q  <= {RSP_ERR, 24'h0};
          seq_cnt_q   <= 3'd1;
          state_q     <= ST_SEND;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ser_tx_seq u_tx_seq (
    .clk        (clk),
    .rst_n      (rst),
    .start_i    (seq_start_q),
    .word_i     (seq_word_q),
    .cnt_i      (seq_cnt_q),
    .txd_busy_i (txd_busy),
    .tx_data_o  (tx_data),
    .txd_ld_o   (txd_ld),
    .active_o   (tx_active)
  );

  assign rxd_ft      = ft_q;
  assign frame_err   = err_q;
  assign bus_addr    = bus_addr_q;
  assign bus_dout    = bus_dout_q;
  assign bus_mem_ctl = ctl_q;

endmodule

// File: doc/ser_bus_master.md
Name: ser_bus_master

Overview:
- Serial-to-bus bridge: the initiator counterpart of the memory-mapped device controller.
- Consumes framed command bytes from the UART receive side (uart0 rxd_rdy/dout/rxd_ft handshake).
- Issues single-word writes and reads on the data-memory bus (addr/dout/mem_ctl, din back).
- Returns acknowledge or read data bytes through the UART transmit side (txd_ld/txd_busy).
- Used for board bring-up: program loading and peripheral poking without the CPU.

Parameters:
- TIMEOUT, 100000: maximum idle cycles between bytes of one frame before the frame is abandoned; must be ≥ 2.
- RD_LAT, 1: cycles from the bus transfer cycle to valid read data on bus_din; legal range 1..3.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- rx_data  in  8  received byte (uart0 dout)
- rxd_rdy  in  1  received byte valid
- rxd_ft  out  1  one-cycle pulse: byte consumed
- tx_data  out  8  byte to transmit
- txd_ld  out  1  one-cycle load pulse to UART transmitter
- txd_busy  in  1  transmitter busy
- bus_addr  out  32  bus address
- bus_dout  out  32  write data
- bus_mem_ctl  out  4  bus command; MEM_IDLE when no request
- bus_gnt  in  1  high in the cycle the request is accepted
- bus_din  in  32  read data
- frame_err  out  1  one-cycle pulse on bad opcode or timeout

Behaviour:
- Reset (rst low, async): state IDLE, rxd_ft=0, txd_ld=0, tx_data=0, bus_addr=0, bus_dout=0, bus_mem_ctl=MEM_IDLE, frame_err=0, all counters 0.
- Frame formats, all multi-byte fields big-endian:
  - Write: 0x57, then A3..A0, then D3..D0. Response: one byte 0x4B.
  - Read: 0x52, then A3..A0. Response: four bytes, D3 first.
- Byte intake: when rxd_rdy=1 in a receiving state, latch rx_data and pulse rxd_ft for exactly one cycle. The next byte is not sampled in the cycle after the pulse; rdy may still be stale there.
- States:
  - IDLE: on byte 0x57 or 0x52, go to GET_ADDR with byte_cnt=0. On any other byte, go to ERR.
  - GET_ADDR: shift each byte into addr_reg. After the 4th byte, a write goes to GET_DATA; a read goes to BUS_REQ.
  - GET_DATA: shift 4 bytes into data_reg, then go to BUS_REQ.
  - BUS_REQ: drive bus_addr, bus_dout, and bus_mem_ctl (`DMEM_SW for write, `DMEM_LW for read). Hold all three stable until a cycle with bus_gnt=1.
    - In the gnt cycle: a write goes to SEND with tx_buf=0x4B and tx_cnt=1; a read goes to BUS_WAIT.
    - bus_mem_ctl returns to MEM_IDLE in the cycle after the gnt cycle.
  - BUS_WAIT: count RD_LAT cycles from the gnt cycle, then capture bus_din into tx_buf. Go to SEND with tx_cnt=4.
  - SEND: when txd_busy=0 and no guard is active, output tx_buf[31:24] (tx_data=0x4B for a write ack) and pulse txd_ld. Shift tx_buf left 8 and decrement tx_cnt.
    - The guard lasts 2 cycles after each txd_ld; txd_busy is ignored during it because busy may rise late.
    - When tx_cnt reaches 0, go to IDLE.
  - ERR: pulse frame_err and transmit 0x3F through the SEND rules, then go to IDLE.
- Timeout: in GET_ADDR and GET_DATA, a counter is cleared on every consumed byte and increments otherwise. Reaching TIMEOUT forces IDLE, pulses frame_err, and sends no response.
- The timeout counter does not run in IDLE, BUS_REQ, BUS_WAIT, or SEND.
- Bytes arriving during BUS_REQ, BUS_WAIT, or SEND are left unconsumed; the UART holds them.
- Reset mid-frame or mid-transfer: immediate return to the reset state; no partial bus cycle completes.

Decomposition:
- Shared package (include.h style) holds:
  - MEM_IDLE=4'd0
  - OP_WR=8'h57, OP_RD=8'h52, RSP_ACK=8'h4B, RSP_ERR=8'h3F
  - state encodings
- `DMEM_SW and `DMEM_LW are reused from include.h.
- One sub-module, ser_tx_seq: handles the SEND byte sequencing, the 2-cycle guard, and tx_cnt.

Test Plan:
- Write frame 57 00 00 10 20 DE AD BE EF with bus_gnt tied to 1 → exactly one cycle with bus_mem_ctl=`DMEM_SW, bus_addr=0x00001020, bus_dout=0xDEADBEEF; then one transmitted byte 0x4B.
- Read frame 52 00 00 10 08, bus_din=0x12345678 valid RD_LAT=1 cycle after gnt → `DMEM_LW at 0x00001008; transmitted bytes 12 34 56 78 in order, each load only while txd_busy=0.
- bus_gnt held low for 5 cycles during a write → addr, data, and mem_ctl stable for all 6 cycles; a single transfer; one ack.
- Opcode byte 0x41 → frame_err pulses once, 0x3F transmitted, and the next valid frame is processed normally.
- Send 57 00 then stall TIMEOUT cycles → frame_err pulses, no bus activity, no response; a fresh 52 frame then completes.
- Drive rst low during BUS_REQ → bus_mem_ctl=MEM_IDLE asynchronously; no transfer or response after release.
